// File: rtl/rtc_bcd_counter_pkg.sv
// rtc_bcd_pkg: shared types and helpers for the BCD counter slice.
//   bcd_digit_t : one BCD nibble
//   BCD_MAX     : largest legal BCD digit value
//   bcd_clamp() : limit a nibble (including non-BCD A-F) to a digit maximum
package rtc_bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Any nibble above the digit maximum, including A-F, saturates to the
  // maximum so a bad load can never leave a digit outside its radix.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t digit,
                                           input bcd_digit_t max);
    return (digit > max) ? max : digit;
  endfunction

endpackage

// File: rtl/rtc_bcd_counter_if.sv
// rtc_bcd_counter_if: control and data bundle between the tick prescaler /
// host and the BCD counter, plus the display and lap outputs.
//   master : drives i_* controls, observes o_* results (host / testbench)
//   slave  : the counter itself
// Signalling: there is no valid/ready handshake. Every i_* control is a
// level or strobe sampled at each rising clock edge; every o_* output is
// registered and changes only on a rising edge (or on reset).
interface rtc_bcd_counter_if #(
  parameter int DIGITS = 6
);
  logic                  i_countenb;
  logic                  i_countdir;
  logic                  i_countinit;
  logic                  i_load;
  logic [4*DIGITS-1:0]   i_loadval;
  logic                  i_latchcount;
  logic                  i_lap;
  logic [4*DIGITS-1:0]   o_count;
  logic                  o_rollover;
  logic [4*DIGITS-1:0]   o_lap;
  logic                  o_lapvalid;

  modport master (
    output i_countenb, i_countdir, i_countinit, i_load, i_loadval,
           i_latchcount, i_lap,
    input  o_count, o_rollover, o_lap, o_lapvalid
  );

  modport slave (
    input  i_countenb, i_countdir, i_countinit, i_load, i_loadval,
           i_latchcount, i_lap,
    output o_count, o_rollover, o_lap, o_lapvalid
  );
endinterface

// File: rtl/rtc_bcd_counter_digit.sv
// rtc_bcd_digit: one BCD digit register of the live count.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear (highest priority)
//   load_i        : synchronous load of load_val_i (clamped to max_i)
//   load_val_i    : raw nibble to load
//   max_i         : largest value of this digit
//   step_i        : counter-wide step enable
//   dir_i         : 0 = up, 1 = down
//   carry_i       : all lower digits are at their terminal value
//   digit_o       : current digit value
//   digit_d_o     : value the digit takes at the next edge
//   term_o        : digit is at its terminal value for the current direction
module rtc_bcd_digit
  import rtc_bcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       load_i,
  input  bcd_digit_t load_val_i,
  input  bcd_digit_t max_i,
  input  logic       step_i,
  input  logic       dir_i,
  input  logic       carry_i,
  output bcd_digit_t digit_o,
  output bcd_digit_t digit_d_o,
  output logic       term_o
);

  bcd_digit_t digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = '0;
    end else if (load_i) begin
      digit_d = bcd_clamp(load_val_i, max_i);
    end else if (step_i && carry_i) begin
      if (!dir_i) digit_d = (digit_q >= max_i) ? 4'd0 : digit_q + 4'd1;
      else        digit_d = (digit_q == 4'd0)  ? max_i : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) digit_q <= '0;
    else         digit_q <= digit_d;
  end

  assign digit_o   = digit_q;
  assign digit_d_o = digit_d;
  assign term_o    = dir_i ? (digit_q == 4'd0) : (digit_q == max_i);

endmodule

// File: rtl/rtc_bcd_counter.sv
// rtc_bcd_counter: parametrised multi-digit mixed-radix BCD counter with
// up/down stepping, load, wrap/saturate, freezable display and lap capture.
//   i_rtcclk  : single clock
//   i_reset_n : asynchronous active-low reset
//   bus       : rtc_bcd_counter_if.slave (controls in, count/rollover/lap out)
// Parameters: DIGITS (digit count), MAXMAP (per-digit maximum, nibble 0 =
// least significant digit, each 1..9), WRAP (1 = wrap, 0 = saturate).
// Build option: define RTC_LAP_EN to include the lap-capture register;
// without it i_lap is ignored and o_lap / o_lapvalid are tied to 0.
module rtc_bcd_counter
  import rtc_bcd_pkg::*;
#(
  parameter int                  DIGITS = 6,
  parameter logic [4*DIGITS-1:0] MAXMAP = 24'h595999,
  parameter int                  WRAP   = 1
) (
  input  logic              i_rtcclk,
  input  logic              i_reset_n,
  rtc_bcd_counter_if.slave  bus
);

  localparam bit HOLD_AT_TERM = (WRAP == 0);

  logic [4*DIGITS-1:0] cnt_q, cnt_d;
  logic [DIGITS-1:0]   term;
  // carry[k] = every digit below k is terminal; carry[DIGITS] = whole count
  // is terminal in the current direction.
  logic [DIGITS:0]     carry;
  logic                all_term, step_en;

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                rollover_q, rollover_d;

  assign carry[0] = 1'b1;
  assign all_term = carry[DIGITS];
  // Saturate mode freezes the digits at the terminal value instead of
  // letting the carry chain wrap them.
  assign step_en  = bus.i_countenb && !(all_term && HOLD_AT_TERM);

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    localparam bcd_digit_t MAXK = MAXMAP[4*k +: 4];
    if (MAXK < 4'd1 || MAXK > BCD_MAX) begin : g_bad_max
      $error("rtc_bcd_counter: MAXMAP digit %0d out of range 1..9", k);
    end

    rtc_bcd_digit u_digit (
      .clk_i      (i_rtcclk),
      .rst_ni     (i_reset_n),
      .clr_i      (bus.i_countinit),
      .load_i     (bus.i_load),
      .load_val_i (bus.i_loadval[4*k +: 4]),
      .max_i      (MAXK),
      .step_i     (step_en),
      .dir_i      (bus.i_countdir),
      .carry_i    (carry[k]),
      .digit_o    (cnt_q[4*k +: 4]),
      .digit_d_o  (cnt_d[4*k +: 4]),
      .term_o     (term[k])
    );

    assign carry[k+1] = carry[k] & term[k];
  end

  // Rollover marks any real step taken from the terminal value, in both
  // modes; clear and load take priority over the step so they never pulse.
  always_comb begin
    rollover_d = bus.i_countenb && !bus.i_countinit && !bus.i_load && all_term;
    // The display follows the post-edge live value, giving zero latency.
    count_d    = bus.i_latchcount ? cnt_d : count_q;
  end

  always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q    <= '0;
      rollover_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rollover_q <= rollover_d;
    end
  end

  assign bus.o_count    = count_q;
  assign bus.o_rollover = rollover_q;

`ifdef RTC_LAP_EN
  logic [4*DIGITS-1:0] lap_q, lap_d;
  logic                lapvalid_q, lapvalid_d;

  // Lap captures the pre-edge live value; clear beats a same-edge capture.
  always_comb begin
    lap_d      = lap_q;
    lapvalid_d = lapvalid_q;
    if (bus.i_countinit) begin
      lap_d      = '0;
      lapvalid_d = 1'b0;
    end else if (bus.i_lap) begin
      lap_d      = cnt_q;
      lapvalid_d = 1'b1;
    end
  end

  always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lap_q      <= '0;
      lapvalid_q <= 1'b0;
    end else begin
      lap_q      <= lap_d;
      lapvalid_q <= lapvalid_d;
    end
  end

  assign bus.o_lap      = lap_q;
  assign bus.o_lapvalid = lapvalid_q;
`else
  // Lap feature absent: keep the port, discard its input.
  logic unused_lap;
  assign unused_lap     = bus.i_lap ^ (^cnt_q);
  assign bus.o_lap      = '0;
  assign bus.o_lapvalid = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bcd_counter.sv
module tb_rtc_bcd_counter;

  localparam logic [23:0] MAXMAP = 24'h595999;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  // bus drives the wrapping counter; bus_s mirrors its inputs into a
  // saturating counter so both modes see identical stimulus.
  rtc_bcd_counter_if #(.DIGITS(6)) bus   ();
  rtc_bcd_counter_if #(.DIGITS(6)) bus_s ();

  assign bus_s.i_countenb   = bus.i_countenb;
  assign bus_s.i_countdir   = bus.i_countdir;
  assign bus_s.i_countinit  = bus.i_countinit;
  assign bus_s.i_load       = bus.i_load;
  assign bus_s.i_loadval    = bus.i_loadval;
  assign bus_s.i_latchcount = bus.i_latchcount;
  assign bus_s.i_lap        = bus.i_lap;

  rtc_bcd_counter #(.DIGITS(6), .MAXMAP(MAXMAP), .WRAP(1)) dut_w (
    .i_rtcclk  (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  rtc_bcd_counter #(.DIGITS(6), .MAXMAP(MAXMAP), .WRAP(0)) dut_s (
    .i_rtcclk  (clk),
    .i_reset_n (rst_n),
    .bus       (bus_s.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef RTC_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  // ---------------- reference model helpers ----------------
  function automatic int max_digit(input int k);
    logic [23:0] m;
    m = MAXMAP;
    return int'(m[4*k +: 4]);
  endfunction

  // Mixed-radix BCD value -> plain elapsed-step index.
  function automatic int to_idx(input logic [23:0] b);
    int idx, mult;
    idx = 0;
    mult = 1;
    for (int k = 0; k < 6; k++) begin
      idx += int'(b[4*k +: 4]) * mult;
      mult *= max_digit(k) + 1;
    end
    return idx;
  endfunction

  function automatic logic [23:0] to_bcd(input int idx);
    logic [23:0] b;
    int r;
    b = '0;
    for (int k = 0; k < 6; k++) begin
      r = max_digit(k) + 1;
      b[4*k +: 4] = 4'(idx % r);
      idx = idx / r;
    end
    return b;
  endfunction

  function automatic logic [23:0] clamp_val(input logic [23:0] b);
    logic [23:0] c;
    c = b;
    for (int k = 0; k < 6; k++)
      if (int'(b[4*k +: 4]) > max_digit(k)) c[4*k +: 4] = 4'(max_digit(k));
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.i_countenb   = 1'b0;
    bus.i_countdir   = 1'b0;
    bus.i_countinit  = 1'b0;
    bus.i_load       = 1'b0;
    bus.i_loadval    = '0;
    bus.i_latchcount = 1'b1;
    bus.i_lap        = 1'b0;
  endtask

  task automatic do_load(input logic [23:0] v);
    bus.i_load    = 1'b1;
    bus.i_loadval = v;
    tick(1);
    bus.i_load    = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    n_cmp++; if (bus.o_count !== 24'h0 || bus_s.o_count !== 24'h0) begin
      n_bad++; $display("FAIL reset_count: got %h/%h want 000000", bus.o_count, bus_s.o_count); end
    n_cmp++; if (bus.o_rollover !== 1'b0 || bus_s.o_rollover !== 1'b0) begin
      n_bad++; $display("FAIL reset_rollover: got %b/%b want 0", bus.o_rollover, bus_s.o_rollover); end
    n_cmp++; if (bus.o_lap !== 24'h0 || bus.o_lapvalid !== 1'b0) begin
      n_bad++; $display("FAIL reset_lap: got %h/%b want 000000/0", bus.o_lap, bus.o_lapvalid); end
    #8;
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_count();
    int roll_seen;
    roll_seen = 0;
    bus.i_countenb = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (bus.o_rollover || bus_s.o_rollover) roll_seen++;
    end
    bus.i_countenb = 1'b0;
    n_cmp++; if (bus.o_count !== 24'h000100) begin
      n_bad++; $display("FAIL count_100_wrap: got %h want 000100", bus.o_count); end
    n_cmp++; if (bus_s.o_count !== 24'h000100) begin
      n_bad++; $display("FAIL count_100_sat: got %h want 000100", bus_s.o_count); end
    n_cmp++; if (roll_seen !== 0) begin
      n_bad++; $display("FAIL count_no_rollover: got %0d pulses want 0", roll_seen); end
  endtask

  task automatic test_up_wrap();
    do_load(24'h595999);
    n_cmp++; if (bus.o_count !== 24'h595999 || bus.o_rollover !== 1'b0) begin
      n_bad++; $display("FAIL load_terminal: got %h/%b want 595999/0", bus.o_count, bus.o_rollover); end
    bus.i_countenb = 1'b1;
    tick(1);
    bus.i_countenb = 1'b0;
    n_cmp++; if (bus.o_count !== 24'h000000 || bus.o_rollover !== 1'b1) begin
      n_bad++; $display("FAIL up_wrap: got %h/%b want 000000/1", bus.o_count, bus.o_rollover); end
    n_cmp++; if (bus_s.o_count !== 24'h595999 || bus_s.o_rollover !== 1'b1) begin
      n_bad++; $display("FAIL up_sat: got %h/%b want 595999/1", bus_s.o_count, bus_s.o_rollover); end
    tick(1);
    n_cmp++; if (bus.o_rollover !== 1'b0 || bus_s.o_rollover !== 1'b0) begin
      n_bad++; $display("FAIL rollover_one_cycle: got %b/%b want 0", bus.o_rollover, bus_s.o_rollover); end
    bus.i_countenb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_cmp++; if (bus_s.o_count !== 24'h595999 || bus_s.o_rollover !== 1'b1) begin
        n_bad++; $display("FAIL sat_hold_step%0d: got %h/%b want 595999/1", i, bus_s.o_count, bus_s.o_rollover); end
    end
    bus.i_countenb = 1'b0;
    n_cmp++; if (bus.o_count !== 24'h000003 || bus.o_rollover !== 1'b0) begin
      n_bad++; $display("FAIL wrap_continue: got %h/%b want 000003/0", bus.o_count, bus.o_rollover); end
  endtask

  task automatic test_down_borrow();
    do_load(24'h010000);
    bus.i_countdir = 1'b1;
    bus.i_countenb = 1'b1;
    tick(1);
    bus.i_countenb = 1'b0;
    n_cmp++; if (bus.o_count !== 24'h005999 || bus_s.o_count !== 24'h005999) begin
      n_bad++; $display("FAIL down_borrow: got %h/%h want 005999", bus.o_count, bus_s.o_count); end
    bus.i_countinit = 1'b1;
    tick(1);
    bus.i_countinit = 1'b0;
    bus.i_countenb = 1'b1;
    tick(1);
    bus.i_countenb = 1'b0;
    n_cmp++; if (bus.o_count !== 24'h595999 || bus.o_rollover !== 1'b1) begin
      n_bad++; $display("FAIL down_wrap: got %h/%b want 595999/1", bus.o_count, bus.o_rollover); end
    n_cmp++; if (bus_s.o_count !== 24'h000000 || bus_s.o_rollover !== 1'b1) begin
      n_bad++; $display("FAIL down_sat: got %h/%b want 000000/1", bus_s.o_count, bus_s.o_rollover); end
    bus.i_countdir = 1'b0;
  endtask

  task automatic test_load_clamp();
    do_load(24'h7A9F99);
    n_cmp++; if (bus.o_count !== 24'h595999 || bus_s.o_count !== 24'h595999) begin
      n_bad++; $display("FAIL load_clamp: got %h/%h want 595999", bus.o_count, bus_s.o_count); end
    // Load beats a step taken from the terminal value: no step, no pulse.
    bus.i_countenb = 1'b1;
    do_load(24'h000042);
    bus.i_countenb = 1'b0;
    n_cmp++; if (bus.o_count !== 24'h000042 || bus.o_rollover !== 1'b0 || bus_s.o_rollover !== 1'b0) begin
      n_bad++; $display("FAIL load_over_step: got %h/%b/%b want 000042/0/0", bus.o_count, bus.o_rollover, bus_s.o_rollover); end
  endtask

  task automatic test_freeze_priority();
    do_load(24'h000050);
    bus.i_latchcount = 1'b0;
    bus.i_countenb   = 1'b1;
    tick(30);
    bus.i_countenb   = 1'b0;
    n_cmp++; if (bus.o_count !== 24'h000050) begin
      n_bad++; $display("FAIL freeze_hold: got %h want 000050", bus.o_count); end
    bus.i_latchcount = 1'b1;
    tick(1);
    n_cmp++; if (bus.o_count !== 24'h000080) begin
      n_bad++; $display("FAIL freeze_release: got %h want 000080", bus.o_count); end
    bus.i_countinit = 1'b1;
    do_load(24'h123456);
    bus.i_countinit = 1'b0;
    n_cmp++; if (bus.o_count !== 24'h000000 || bus_s.o_count !== 24'h000000) begin
      n_bad++; $display("FAIL init_over_load: got %h/%h want 000000", bus.o_count, bus_s.o_count); end
    do_load(24'h000077);
    bus.i_latchcount = 1'b0;
    bus.i_countinit  = 1'b1;
    tick(1);
    bus.i_countinit  = 1'b0;
    n_cmp++; if (bus.o_count !== 24'h000077) begin
      n_bad++; $display("FAIL init_frozen_display: got %h want 000077", bus.o_count); end
    bus.i_latchcount = 1'b1;
    tick(1);
    n_cmp++; if (bus.o_count !== 24'h000000) begin
      n_bad++; $display("FAIL init_live_cleared: got %h want 000000", bus.o_count); end
  endtask

  task automatic test_lap();
    logic [23:0] exp_lap;
    do_load(24'h000120);
    bus.i_countenb = 1'b1;
    tick(3);
    bus.i_lap = 1'b1;
    tick(1);
    bus.i_lap = 1'b0;
    exp_lap = LAP_EN ? 24'h000123 : 24'h000000;
    n_cmp++; if (bus.o_lap !== exp_lap || bus.o_lapvalid !== LAP_EN) begin
      n_bad++; $display("FAIL lap_capture: got %h/%b want %h/%b", bus.o_lap, bus.o_lapvalid, exp_lap, LAP_EN); end
    n_cmp++; if (bus.o_count !== 24'h000124) begin
      n_bad++; $display("FAIL lap_count_on: got %h want 000124", bus.o_count); end
    tick(2);
    bus.i_countenb = 1'b0;
    n_cmp++; if (bus.o_count !== 24'h000126 || bus.o_lap !== exp_lap) begin
      n_bad++; $display("FAIL lap_hold: got %h/%h want 000126/%h", bus.o_count, bus.o_lap, exp_lap); end
    bus.i_countinit = 1'b1;
    tick(1);
    bus.i_countinit = 1'b0;
    n_cmp++; if (bus.o_lapvalid !== 1'b0 || bus.o_lap !== 24'h0) begin
      n_bad++; $display("FAIL lap_clear: got %h/%b want 000000/0", bus.o_lap, bus.o_lapvalid); end
    do_load(24'h000321);
    bus.i_lap = 1'b1;
    bus.i_countinit = 1'b1;
    tick(1);
    bus.i_lap = 1'b0;
    bus.i_countinit = 1'b0;
    n_cmp++; if (bus.o_lapvalid !== 1'b0 || bus.o_lap !== 24'h0) begin
      n_bad++; $display("FAIL lap_vs_init: got %h/%b want 000000/0", bus.o_lap, bus.o_lapvalid); end
  endtask

  task automatic test_reset_mid();
    do_load(24'h595999);
    bus.i_countenb = 1'b1;
    bus.i_lap = 1'b1;
    tick(1);
    bus.i_lap = 1'b0;
    n_cmp++; if (bus.o_rollover !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_pulse: got %b want 1", bus.o_rollover); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.o_count !== 24'h0 || bus_s.o_count !== 24'h0 || bus.o_rollover !== 1'b0 || bus_s.o_rollover !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: got %h/%h/%b/%b want 0", bus.o_count, bus_s.o_count, bus.o_rollover, bus_s.o_rollover); end
    n_cmp++; if (bus.o_lapvalid !== 1'b0 || bus.o_lap !== 24'h0) begin
      n_bad++; $display("FAIL async_reset_lap: got %h/%b want 000000/0", bus.o_lap, bus.o_lapvalid); end
    bus.i_countenb = 1'b0;
    #3 rst_n = 1'b1;
    tick(1);
    n_cmp++; if (bus.o_rollover !== 1'b0 || bus_s.o_rollover !== 1'b0 || bus.o_count !== 24'h0) begin
      n_bad++; $display("FAIL post_reset_quiet: got %h/%b/%b want 000000/0/0", bus.o_count, bus.o_rollover, bus_s.o_rollover); end
  endtask

  task automatic test_random();
    // index 1 = wrapping counter, index 0 = saturating counter
    int          m_cnt  [2];
    logic [23:0] m_disp [2];
    logic [23:0] m_lap  [2];
    logic        m_roll [2];
    logic        m_lapv [2];
    int          nst, old, nc, sel;
    logic        term;
    logic [23:0] lv;
    nst = to_idx(MAXMAP) + 1;
    for (int w = 0; w < 2; w++) begin
      m_cnt[w] = 0; m_disp[w] = '0; m_lap[w] = '0; m_roll[w] = 1'b0; m_lapv[w] = 1'b0;
    end
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 3);
      lv  = (sel == 0) ? 24'h595999 : (sel == 1) ? 24'h000000 :
            (sel == 2) ? 24'h595998 : 24'($urandom);
      bus.i_countinit  = (i == 0) || ($urandom_range(0, 31) == 0);
      bus.i_load       = ($urandom_range(0, 15) == 0);
      bus.i_loadval    = lv;
      bus.i_countenb   = ($urandom_range(0, 3) != 0);
      bus.i_countdir   = 1'($urandom_range(0, 1));
      bus.i_latchcount = (i == 0) || ($urandom_range(0, 7) != 0);
      bus.i_lap        = ($urandom_range(0, 15) == 0);
      for (int w = 0; w < 2; w++) begin
        old = m_cnt[w];
        if (bus.i_countinit) begin
          nc = 0; m_roll[w] = 1'b0;
        end else if (bus.i_load) begin
          nc = to_idx(clamp_val(lv)); m_roll[w] = 1'b0;
        end else if (bus.i_countenb) begin
          term = bus.i_countdir ? (old == 0) : (old == nst - 1);
          m_roll[w] = term;
          if (term && w == 0) nc = old;
          else nc = bus.i_countdir ? (old + nst - 1) % nst : (old + 1) % nst;
        end else begin
          nc = old; m_roll[w] = 1'b0;
        end
        m_cnt[w] = nc;
        if (bus.i_latchcount) m_disp[w] = to_bcd(nc);
        if (LAP_EN) begin
          if (bus.i_countinit) begin
            m_lap[w] = '0; m_lapv[w] = 1'b0;
          end else if (bus.i_lap) begin
            m_lap[w] = to_bcd(old); m_lapv[w] = 1'b1;
          end
        end
      end
      tick(1);
      n_cmp++; if (bus.o_count !== m_disp[1] || bus.o_rollover !== m_roll[1]) begin
        n_bad++; $display("FAIL rand_wrap cyc%0d: got %h/%b want %h/%b", i, bus.o_count, bus.o_rollover, m_disp[1], m_roll[1]); end
      n_cmp++; if (bus_s.o_count !== m_disp[0] || bus_s.o_rollover !== m_roll[0]) begin
        n_bad++; $display("FAIL rand_sat cyc%0d: got %h/%b want %h/%b", i, bus_s.o_count, bus_s.o_rollover, m_disp[0], m_roll[0]); end
      n_cmp++; if (bus.o_lap !== m_lap[1] || bus.o_lapvalid !== m_lapv[1] ||
                   bus_s.o_lap !== m_lap[0] || bus_s.o_lapvalid !== m_lapv[0]) begin
        n_bad++; $display("FAIL rand_lap cyc%0d: got %h/%b %h/%b want %h/%b %h/%b", i, bus.o_lap, bus.o_lapvalid,
                          bus_s.o_lap, bus_s.o_lapvalid, m_lap[1], m_lapv[1], m_lap[0], m_lapv[0]); end
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_count();
    test_up_wrap();
    test_down_borrow();
    test_load_clamp();
    test_freeze_priority();
    test_lap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
